// File: rtl/load_align_pkg.sv
// Shared load-path types: access-size encoding, load FSM states, lane masks
// and the alignment legality rule.
package load_align_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DONE
  } state_e;

  localparam logic [31:0] MASK_BYTE = 32'h0000_00FF;
  localparam logic [31:0] MASK_HALF = 32'h0000_FFFF;
  localparam logic [31:0] MASK_WORD = 32'hFFFF_FFFF;

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic req_legal(input size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~lo[0];
      SZ_WORD: return (lo == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align_mask_gen.sv
// Size-to-lane-mask decode for the downstream filter.
module mask_gen
  import load_align_pkg::*;
(
  input  size_e       size,
  output logic [31:0] mask
);

  always_comb begin
    mask = '0;
    case (size)
      SZ_BYTE: mask = MASK_BYTE;
      SZ_HALF: mask = MASK_HALF;
      SZ_WORD: mask = MASK_WORD;
      default: mask = '0;
    endcase
  end

endmodule

// File: rtl/load_align.sv
// Load aligner: fetches the containing word, right-justifies the addressed
// bytes and supplies a lane mask; rejects misaligned requests and times out.
module load_align
  import load_align_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  output logic        busy,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data,
  output logic [31:0] data,
  output logic [31:0] mask,
  output logic        done,
  output logic        err
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  size_e       size_q, size_d;
  logic [31:0] data_q, data_d;
  logic [31:0] mask_q, mask_d;
  logic        err_q, err_d;
  logic [31:0] mask_dec;
  logic [4:0]  shamt;

  mask_gen u_mask_gen (
    .size (size_q),
    .mask (mask_dec)
  );

  assign shamt = {addr_q[1:0], 3'b000};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    data_d  = data_q;
    mask_d  = mask_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (req_legal(size_e'(size), addr[1:0])) begin
            addr_d  = addr;
            size_d  = size_e'(size);
            cnt_d   = '0;
            state_d = ST_READ;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_READ: begin
        // An ack in the final allowed cycle takes precedence over the timeout.
        if (mem_ack) begin
          data_d  = mem_data >> shamt;
          mask_d  = mask_dec;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      size_q  <= SZ_BYTE;
      data_q  <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign mem_rd   = (state_q == ST_READ);
  assign done     = (state_q == ST_DONE);
  assign mem_addr = {addr_q[31:2], 2'b00};
  assign data     = data_q;
  assign mask     = mask_q;
  assign err      = err_q;

endmodule

// File: tb/tb_load_align.sv
// Scoreboard bench for load_align: a driver pushes expected completions from a
// behavioural model, a negedge monitor pops and compares them.
module tb_load_align;

  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        rst, start, mem_ack;
  logic [31:0] addr, mem_data;
  logic [1:0]  size;
  logic        busy, mem_rd, done, err;
  logic [31:0] mem_addr, data, mask;

  load_align #(.TIMEOUT(T)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .addr     (addr),
    .size     (size),
    .busy     (busy),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_data (mem_data),
    .data     (data),
    .mask     (mask),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    int unsigned at;
    logic [31:0] data;
    logic [31:0] mask;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_data = '0;
  logic [31:0] m_mask = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_mask(input int sz);
    if (sz == 0) return 32'h0000_00FF;
    if (sz == 1) return 32'h0000_FFFF;
    return 32'hFFFF_FFFF;
  endfunction

  function automatic bit ref_legal(input logic [31:0] a, input int sz);
    return (sz == 0) || (sz == 1 && a % 2 == 0) || (sz == 2 && a % 4 == 0);
  endfunction

  // ackc: READ cycle (1-based) carrying mem_ack; 0 or >T means none in time.
  task automatic do_load(input logic [31:0] a, input int sz, input int ackc, input logic [31:0] md);
    exp_t        e;
    int unsigned c0;
    bit          legal;
    @(posedge clk); #1;
    start = 1'b1; addr = a; size = 2'(sz); mem_ack = 1'b0;
    c0 = cyc;
    legal = ref_legal(a, sz);
    if (!legal) begin
      e.is_err = 1'b1; e.at = c0 + 1; e.data = m_data; e.mask = m_mask;
    end else if (ackc >= 1 && ackc <= int'(T)) begin
      m_data = md >> (8 * (a % 4));
      m_mask = ref_mask(sz);
      e.is_err = 1'b0; e.at = c0 + ackc + 1; e.data = m_data; e.mask = m_mask;
    end else begin
      e.is_err = 1'b1; e.at = c0 + T + 1; e.data = m_data; e.mask = m_mask;
    end
    sb.push_back(e);
    if (!legal) begin
      @(posedge clk); #1;
      start = 1'b0;
      chk("illegal_mem_rd", 32'(mem_rd), 32'd0);
      chk("illegal_busy", 32'(busy), 32'd0);
    end else begin
      for (int j = 1; j <= int'(T); j++) begin
        @(posedge clk); #1;
        start = 1'($urandom_range(0, 1));
        addr  = $urandom;
        size  = 2'($urandom_range(0, 3));
        chk("read_mem_rd", 32'(mem_rd), 32'd1);
        chk("read_mem_addr", mem_addr, {a[31:2], 2'b00});
        mem_ack  = (j == ackc);
        mem_data = (j == ackc) ? md : $urandom;
        if (j == ackc) break;
      end
      @(posedge clk); #1;
      start = 1'b0; mem_ack = 1'b0;
      chk("post_read_mem_rd", 32'(mem_rd), 32'd0);
    end
    @(posedge clk); #1;
    start = 1'b0;
    mem_ack = 1'($urandom_range(0, 1));
    mem_data = $urandom;
    chk("gap_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_data"}, data, 32'd0);
    chk({tag, "_mask"}, mask, 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic reset_mid_read();
    @(posedge clk); #1;
    start = 1'b1; addr = 32'h300; size = 2'd2; mem_ack = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("rstmid_mem_rd", 32'(mem_rd), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_ack = 1'b1; mem_data = $urandom;
    m_data = '0; m_mask = '0;
    check_all_zero("rstmid");
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("rstmid_done", 32'(done), 32'd0);
    chk("rstmid_err", 32'(err), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && (done || err)) begin
      exp_t e;
      if (done && err) chk("done_err_overlap", 32'd1, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_completion", {30'd0, done, err}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("kind_err", 32'(err), 32'(e.is_err));
        chk("completion_cycle", cyc, e.at);
        chk("data", data, e.data);
        chk("mask", mask, e.mask);
        if (done) chk("filter_out", data & mask, e.data & e.mask);
        if (err) chk("err_mem_rd", 32'(mem_rd), 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; mem_ack = 1'b0; addr = '0; size = '0; mem_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    do_load(32'h0000_0103, 0, 2, 32'hAABB_CCDD);
    chk("byte_data", data, 32'h0000_00AA);
    do_load(32'h0000_0100, 1, 3, 32'h1234_5678);
    chk("half_filter", data & mask, 32'h0000_5678);
    do_load(32'h0000_0200, 2, 1, 32'hDEAD_BEEF);
    do_load(32'h0000_0101, 1, 1, 32'h1111_1111);
    chk("misaligned_data_kept", data, 32'hDEAD_BEEF);
    do_load(32'h0000_0400, 2, 0, 32'h2222_2222);
    do_load(32'h0000_0404, 2, int'(T), 32'h3333_4444);
    do_load(32'h0000_0003, 3, 1, 32'h5555_5555);
    reset_mid_read();
    do_load(32'h0000_0502, 1, 2, 32'hCAFE_F00D);
    chk("after_reset_data", data, 32'h0000_CAFE);

    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      do_load(a, int'($urandom_range(0, 3)), int'($urandom_range(0, T + 1)), $urandom);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_align.md
LOAD_ALIGN -- requirements
Module: load_align

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum number of READ-state cycles to wait for mem_ack; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  load request; sampled only in IDLE.
REQ-005 addr  input  32  byte address of the load.
REQ-006 size  input  2  0=byte, 1=halfword, 2=word, 3=reserved.
REQ-007 busy  output  1  high whenever the state is not IDLE.
REQ-008 mem_rd  output  1  memory read strobe.
REQ-009 mem_addr  output  32  word-aligned address: captured addr[31:2], low bits 2'b00.
REQ-010 mem_ack  input  1  memory has valid mem_data this cycle.
REQ-011 mem_data  input  32  read word from memory.
REQ-012 data  output  32  mem_data logically shifted right by 8*addr[1:0]; unmasked; feeds the downstream filter in port.
REQ-013 mask  output  32  lane mask for the filter: 0x000000FF byte, 0x0000FFFF half, 0xFFFFFFFF word.
REQ-014 done  output  1  one-cycle pulse when data and mask are valid.
REQ-015 err  output  1  one-cycle pulse on rejected or timed-out request.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, READ, DONE.
REQ-017 In IDLE, with start=1 and a legal request, the block SHALL capture addr and size and enter READ next cycle.
REQ-018 A request SHALL be illegal when size=3, when size=1 with addr[0]=1, or when size=2 with addr[1:0]!=0.
REQ-019 On an illegal request, the block SHALL pulse err in the following cycle, stay in IDLE, and never assert mem_rd.
REQ-020 mem_rd SHALL be high in every READ cycle and low in every other state, including on the cycle err pulses.
REQ-021 mem_addr SHALL hold its value for the whole of READ.
REQ-022 In a READ cycle with mem_ack=1, the block SHALL register data and mask and enter DONE; done SHALL be high for that single DONE cycle, after which the FSM returns to IDLE.
REQ-023 Latency: start in cycle 0 gives mem_rd in cycle 1; mem_ack in cycle k (k>=1) gives done in cycle k+1.
REQ-024 A wait counter SHALL count READ cycles. If TIMEOUT READ cycles pass without mem_ack, the block SHALL pulse err in the next cycle and enter IDLE. An ack in the last allowed cycle SHALL win over the timeout.
REQ-025 data and mask SHALL hold their values until the next successful completion; err SHALL NOT change them.
REQ-026 start SHALL be ignored in READ and DONE; no request queueing.
REQ-027 mem_ack outside READ SHALL be ignored.
REQ-028 done and err SHALL never be high in the same cycle.

Reset
REQ-029 While rst=1, the block SHALL force state=IDLE, counter=0, mem_rd=0, mem_addr=0, data=0, mask=0, done=0, err=0, busy=0.
REQ-030 Reset during READ SHALL abort the load with no done or err pulse; mem_rd SHALL be low in the cycle after rst is sampled high.
REQ-031 rst SHALL take priority over start and mem_ack in the same cycle.

Structure
REQ-032 The size encoding enum (byte/half/word/reserved) and the FSM state enum SHALL be defined in the shared CPU package.
REQ-033 The size-to-mask decode SHALL be a separate combinational sub-module, mask_gen (input size, output mask 32).
REQ-034 load_align SHALL be instantiable directly ahead of the filter, with data connected to in and mask connected to mask.

Verification
REQ-035 Bench scenario, byte load: size=0, addr=0x103, ack in cycle 2 with mem_data=0xAABBCCDD -> mem_addr=0x100; done in cycle 3; data=0x000000AA; mask=0x000000FF.
REQ-036 Bench scenario, half load: size=1, addr=0x100, mem_data=0x12345678 -> data=0x12345678; mask=0x0000FFFF; filter output=0x00005678.
REQ-037 Bench scenario, immediate ack: size=2, addr=0x200, ack in cycle 1 with mem_data=0xDEADBEEF -> done in cycle 2; data=0xDEADBEEF; mask=0xFFFFFFFF.
REQ-038 Bench scenario, misaligned half: size=1, addr=0x101 -> err in cycle 1; mem_rd never high; data and mask unchanged.
REQ-039 Bench scenario, timeout: TIMEOUT=4, no ack -> mem_rd high in cycles 1-4; err in cycle 5; busy low in cycle 6. With ack in cycle 4 instead -> done in cycle 5 and no err.
REQ-040 Bench scenario, reset mid-READ: rst high in cycle 2, then ack in cycle 3 -> no done, no err; all outputs 0; a new start is accepted afterwards.
